// File: rtl/ci_seq_pkg.sv
// Shared types and constants for the custom-instruction sequencer.
package ci_seq_pkg;

   localparam int DATA_W      = 32;
   localparam int DEF_TIMEOUT = 1024;

   // Single-precision operands used when exercising the evaluate responder
   localparam logic [DATA_W-1:0] FP_128 = 32'h4300_0000;
   localparam logic [DATA_W-1:0] FP_ONE = 32'h3F80_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUTPUT,
      S_FINISH
   } seq_state_t;

endpackage

// File: rtl/ci_sample_buf.sv
// Sample store for the sequencer: synchronous write, asynchronous read.
// Storage is not reset; the owner's sample count says which entries are live.
module ci_sample_buf
   import ci_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write one entry per accepted host strobe
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ci_sequencer.sv
// Custom-instruction initiator: buffers host samples, issues them one at a
// time over the start/done handshake, and streams each result out with its
// buffer index. Every transaction is bounded by a TIMEOUT-cycle watchdog.
module ci_sequencer
   import ci_seq_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clk_en,
   input  logic                     wr_en,
   input  logic [31:0]              wr_data,
   input  logic                     go,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     run_done,
   output logic                     timeout_err,
   output logic                     ci_start,
   output logic [31:0]              ci_dataa,
   input  logic                     ci_done,
   input  logic [31:0]              ci_result,
   output logic                     res_valid,
   output logic [31:0]              res_data,
   output logic [$clog2(DEPTH)-1:0] res_index,
   input  logic                     res_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   seq_state_t        state;
   logic [AW-1:0]     idx;
   logic [TW-1:0]     timer;

   logic              wr_ok;
   logic [CW-1:0]     count_after;
   logic              last_sample;
   logic              timer_expired;
   logic [AW-1:0]     rd_idx;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] issue_data;

   // Host writes land only while idle and not full
   assign wr_ok       = clk_en & wr_en & (state == S_IDLE) & (count < CW'(DEPTH));
   assign count_after = count + {{(CW-1){1'b0}}, wr_ok};

   assign last_sample   = ({1'b0, idx} == (count - CW'(1)));
   assign timer_expired = (timer == TW'(TIMEOUT - 1));

   // The operand is registered on the edge that enters ISSUE, so the read
   // address looks ahead: entry 0 when leaving IDLE, idx+1 when leaving OUTPUT.
   assign rd_idx = (state == S_OUTPUT) ? (idx + AW'(1)) : '0;

   // A write and go in the same idle cycle with an empty buffer: the sample is
   // not in storage yet, so forward it straight to the operand register.
   assign issue_data = (wr_ok && (count == '0)) ? wr_data : rd_data;

   ci_sample_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clock   (clock),
      .wr_en   (wr_ok),
      .wr_idx  (count[AW-1:0]),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   // Run-control FSM with registered handshake, status and result outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         timer       <= '0;
         count       <= '0;
         busy        <= 1'b0;
         run_done    <= 1'b0;
         timeout_err <= 1'b0;
         ci_start    <= 1'b0;
         ci_dataa    <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_index   <= '0;
      end else if (clk_en) begin
         ci_start <= 1'b0;
         run_done <= 1'b0;
         case (state)
            S_IDLE: begin
               count <= count_after;
               if (go) begin
                  if (count_after != '0) begin
                     state       <= S_ISSUE;
                     busy        <= 1'b1;
                     idx         <= '0;
                     timeout_err <= 1'b0;
                     ci_start    <= 1'b1;
                     ci_dataa    <= issue_data;
                  end else begin
                     run_done <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (ci_done) begin
                  res_data  <= ci_result;
                  res_index <= idx;
                  res_valid <= 1'b1;
                  state     <= S_OUTPUT;
               end else if (timer_expired) begin
                  timeout_err <= 1'b1;
                  run_done    <= 1'b1;
                  state       <= S_FINISH;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_OUTPUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (last_sample) begin
                     run_done <= 1'b1;
                     state    <= S_FINISH;
                  end else begin
                     idx      <= idx + AW'(1);
                     ci_start <= 1'b1;
                     ci_dataa <= rd_data;
                     state    <= S_ISSUE;
                  end
               end
            end
            S_FINISH: begin
               count <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ci_sequencer.md
# ci_sequencer

Initiator for the custom-instruction handshake (`start`/`dataa` out, `done`/`result` in) used by the floating-point datapath blocks.
- Buffers up to DEPTH input samples loaded by the host.
- On `go`, issues them one at a time to a single attached responder, such as the evaluate unit.
- Returns each responder result on a ready/valid output stream.
- Guards every transaction with a timeout.

## Interface

Parameters:
- DEPTH, 16: sample buffer entries; power of two, ≥2.
- TIMEOUT, 1024: maximum cycles from `ci_start` to `ci_done` before abort.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clk_en  in  1  when low, every register, including the timeout counter, holds its value.
- wr_en  in  1  host sample write strobe.
- wr_data  in  32  IEEE-754 single-precision sample.
- go  in  1  start-run request.
- busy  out  1  high in every state except IDLE.
- count  out  $clog2(DEPTH)+1  number of samples loaded.
- run_done  out  1  one-cycle pulse at the end of a run.
- timeout_err  out  1  sticky; cleared only by an accepted `go` or by `reset`.
- ci_start  out  1  one-cycle request pulse to the responder.
- ci_dataa  out  32  operand; held stable from `ci_start` until the transaction ends.
- ci_done  in  1  responder completion.
- ci_result  in  32  responder result; valid while `ci_done` is high.
- res_valid  out  1  result available.
- res_data  out  32  captured `ci_result`.
- res_index  out  $clog2(DEPTH)  buffer index the result belongs to.
- res_ready  in  1  consumer accept.

## Operation

States: IDLE, ISSUE, WAIT, OUTPUT, FINISH. All transitions are qualified by `clk_en`.

- **IDLE**
  - `wr_en` with count<DEPTH writes `buf[count]` and increments `count`. A write when full is dropped.
  - `go` with count>0 (after any same-cycle write): go to ISSUE, set idx=0, clear `timeout_err`.
  - `go` with count==0: stay in IDLE and pulse `run_done` next cycle.
- **ISSUE**
  - `ci_start`=1 and `ci_dataa`=`buf[idx]` for exactly one cycle.
  - Clear the timer, then go to WAIT.
  - `wr_en` is ignored in every state except IDLE.
- **WAIT**
  - The timer increments each enabled cycle.
  - `ci_done`=1: capture `ci_result` into `res_data` and idx into `res_index`, then go to OUTPUT.
  - Otherwise, timer==TIMEOUT-1: set `timeout_err`, go to FINISH, discard the remaining samples.
  - If `ci_done` arrives in the same cycle as the timeout, `ci_done` wins.
- **OUTPUT**
  - `res_valid`=1; `res_data` and `res_index` are held until `res_ready`.
  - On the handshake: if idx==count-1, go to FINISH; otherwise increment idx and go to ISSUE.
- **FINISH**
  - `run_done`=1 for one cycle, `count` is cleared to 0, then go to IDLE.
- `ci_done` is ignored outside WAIT. A `ci_done` high in the ISSUE cycle is not sampled.
- Reset mid-run:
  - all outputs go to 0 immediately and the state returns to IDLE;
  - buffer contents are don't-care because `count`=0;
  - a late responder `ci_done` after reset is ignored.

## Timing

- Reset values: `busy`, `run_done`, `timeout_err`, `ci_start`, `res_valid`=0; `ci_dataa`, `res_data`, `res_index`, `count`=0.
- Take `go` as sampled at edge 0 and the responder latency as L cycles from `ci_start` to `ci_done`, L≥1.
  - `ci_start` is high in cycle 1.
  - `ci_done` arrives in cycle 1+L.
  - `res_valid` rises in cycle 2+L.
- With `res_ready` tied high:
  - the next `ci_start` is in cycle 3+L, so the per-sample period is L+2;
  - `run_done` is high in cycle N(L+2)+1 for N samples.
- `res_ready` stalls extend OUTPUT one-for-one and do not advance the timer.
- Timeout abort: `run_done` is high TIMEOUT+1 cycles after `ci_start`.

## Structure

- Package `ci_seq_pkg`:
  - state enum;
  - DATA_W=32;
  - default TIMEOUT;
  - FP constants used by the bench: 0x43000000 (128.0) and 0x3F800000 (1.0).
- Sub-module `ci_sample_buf`: DEPTH×32 register file with a synchronous write and an asynchronous read at idx. It has no reset on the storage.

## Test plan

- Stub responder with L=5 returning dataa+1. Load 3 samples 0x10/0x20/0x30, pulse `go`, hold `res_ready` high. Required response:
  - results 0x11/0x21/0x31 at indices 0/1/2;
  - `ci_start` at cycles 1/8/15;
  - `run_done` at cycle 22;
  - `count`=0 afterwards.
- Real evaluate responder. Load 0x43000000 (128.0) and pulse `go`. Required: `res_data`=0x3F800000 (cos 0 = 1.0).
- `res_ready` low for 10 cycles on the first result. Required:
  - `res_valid`, `res_data` and `ci_dataa` stay stable;
  - no second `ci_start` until the handshake.
- Stub that never asserts `ci_done`, TIMEOUT=16, 2 samples loaded. Required:
  - `timeout_err`=1 and `run_done` 17 cycles after `ci_start`;
  - second sample never issued;
  - a later `go` clears `timeout_err`.
- Write 17 samples with DEPTH=16. Required: `count`=16 and the 17th is dropped. Then pulse `go` with `wr_en` in the same cycle after a reset. Required: the run covers that single sample.
- Assert `reset` in WAIT while the stub later pulses `ci_done`. Required: outputs go to 0 immediately, the late `ci_done` is ignored, and `busy`=0.
- `clk_en` low for 20 cycles during WAIT with TIMEOUT=16. Required: no timeout; the run completes normally.
